// File: rtl/key_cmd_pkg.sv
// Shared types and constants for the key-to-command frame streamer.
// Frames are stored byte 0 in the least significant bits.
package key_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  localparam logic [47:0] FRAME_QUERY     = 48'h0084_D302_5A55;
  localparam logic [47:0] FRAME_RADAR_ON  = 48'h8401_D103_5A55;
  localparam logic [47:0] FRAME_RADAR_OFF = 48'h8300_D103_5A55;

  function automatic int idxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_cmd_streamer_debounce.sv
// Per-key synchroniser, debounce counter and press/auto-repeat event.
// Event is a one-cycle pulse aligned with the Pressed rising edge.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_CYCLES   = 50000000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Key,
  output logic Pressed,
  output logic Event
);

  localparam int DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RpW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RpW-1:0] RpMax = RpW'(REPEAT_CYCLES - 1);
  localparam logic IdleLvl = ACTIVE_LOW;

  logic sync1, sync2, level;
  logic [DbW-1:0] dbCnt;
  logic [RpW-1:0] rpCnt;

  assign level = sync2 ^ ACTIVE_LOW;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1   <= IdleLvl;
      sync2   <= IdleLvl;
      dbCnt   <= '0;
      rpCnt   <= '0;
      Pressed <= 1'b0;
      Event   <= 1'b0;
    end else begin
      sync1 <= Key;
      sync2 <= sync1;
      Event <= 1'b0;
      if (level == Pressed) begin
        dbCnt <= '0;
      end else if (dbCnt == DbMax) begin
        dbCnt   <= '0;
        Pressed <= level;
        Event   <= level;
      end else begin
        dbCnt <= dbCnt + 1'b1;
      end
      // repeat period is counted from the cycle Pressed goes high
      if (!Pressed) begin
        rpCnt <= '0;
      end else if (REPEAT_EN && rpCnt == RpMax) begin
        rpCnt <= '0;
        Event <= 1'b1;
      end else if (REPEAT_EN) begin
        rpCnt <= rpCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_cmd_streamer.sv
// Debounced keys queue per-key command frames, streamed one byte
// per valid/ready handshake with optional auto-repeat.
module key_cmd_streamer
  import key_cmd_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_BYTES       = 6,
  parameter logic [NUM_KEYS*MAX_BYTES*8-1:0] CMD_TABLE =
    {FRAME_RADAR_ON, FRAME_QUERY},
  parameter logic [NUM_KEYS*4-1:0] CMD_LEN = {4'd6, 4'd5},
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_CYCLES   = 50000000
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NUM_KEYS-1:0]       Key,
  output logic [7:0]                TxData,
  output logic                      TxValid,
  output logic                      TxLast,
  input  logic                      TxReady,
  output logic                      Busy,
  output logic [NUM_KEYS-1:0]       KeyState,
  output logic                      CmdDone,
  output logic [idxW(NUM_KEYS)-1:0] CmdKey,
  output logic                      Overrun
);

  localparam int KW = idxW(NUM_KEYS);
  localparam int BW = $clog2(NUM_KEYS * MAX_BYTES * 8);
  localparam logic [3:0] MaxLen = (MAX_BYTES > 15) ? 4'd15 : 4'(MAX_BYTES);

  state_t state, stateNext;
  logic [NUM_KEYS-1:0] evt, pending, clrMask;
  logic [KW-1:0] cmdKeyNext;
  logic [3:0] idx, idxNext, len, lenNext;
  logic [BW-1:0] bitSel;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : gKey
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW(KEY_ACTIVE_LOW),
      .REPEAT_EN(REPEAT_EN),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) uDeb (
      .Clk(Clk),
      .Rst(Rst),
      .Key(Key[k]),
      .Pressed(KeyState[k]),
      .Event(evt[k])
    );
  end

  always_comb begin
    stateNext  = state;
    idxNext    = idx;
    lenNext    = len;
    cmdKeyNext = CmdKey;
    clrMask    = '0;
    unique case (state)
      IDLE: begin
        // descending scan so the lowest pending index wins
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
          if (pending[k]) begin
            cmdKeyNext = KW'(k);
            lenNext = (CMD_LEN[k*4 +: 4] > MaxLen) ?
                      MaxLen : CMD_LEN[k*4 +: 4];
            clrMask    = '0;
            clrMask[k] = 1'b1;
          end
        end
        if (|pending) begin
          idxNext = '0;
          if (lenNext != 4'd0) stateNext = SEND;
        end
      end
      SEND: begin
        if (TxReady) begin
          if (idx == len - 4'd1) stateNext = DONE;
          else idxNext = idx + 4'd1;
        end
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      idx     <= '0;
      len     <= '0;
      CmdKey  <= '0;
      pending <= '0;
      Overrun <= 1'b0;
    end else begin
      state   <= stateNext;
      idx     <= idxNext;
      len     <= lenNext;
      CmdKey  <= cmdKeyNext;
      pending <= (pending & ~clrMask) | evt;
      Overrun <= |(evt & pending & ~clrMask);
    end
  end

  assign bitSel  = BW'((int'(CmdKey) * MAX_BYTES + int'(idx)) * 8);
  assign TxValid = (state == SEND);
  assign TxLast  = TxValid && (idx == len - 4'd1);
  assign TxData  = TxValid ? CMD_TABLE[bitSel +: 8] : 8'h00;
  assign Busy    = (state != IDLE);
  assign CmdDone = (state == DONE);

endmodule

// File: tb/tb_key_cmd_streamer.sv
// Randomised bench for key_cmd_streamer against a frame-level model.
// dutA: no repeat; dutB: auto-repeat every 8 cycles.
module tb_key_cmd_streamer;

  localparam int DB = 4;
  localparam int RC = 8;
  localparam logic [95:0] TABLE = {48'h8401D1035A55, 48'h0084D3025A55};
  localparam logic [7:0]  LENS  = {4'd6, 4'd5};

  logic [7:0] refFrame [2][6] = '{
    '{8'h55, 8'h5A, 8'h02, 8'hD3, 8'h84, 8'h00},
    '{8'h55, 8'h5A, 8'h03, 8'hD1, 8'h01, 8'h84}
  };
  int refLen [2] = '{5, 6};

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic [1:0] keyA = 2'b11, keyB = 2'b11;
  logic readyA = 1'b0, readyB = 1'b0;
  logic [7:0] dataA, dataB;
  logic validA, validB, lastA, lastB, busyA, busyB;
  logic doneA, doneB, ovrA, ovrB, cmdKeyA, cmdKeyB;
  logic [1:0] ksA, ksB;

  int nChk = 0;
  int nFail = 0;

  always #5 Clk = ~Clk;

  key_cmd_streamer #(
    .NUM_KEYS(2), .DEBOUNCE_CYCLES(DB), .MAX_BYTES(6),
    .CMD_TABLE(TABLE), .CMD_LEN(LENS), .KEY_ACTIVE_LOW(1'b1),
    .REPEAT_EN(1'b0), .REPEAT_CYCLES(RC)
  ) dutA (
    .Clk(Clk), .Rst(Rst), .Key(keyA), .TxData(dataA),
    .TxValid(validA), .TxLast(lastA), .TxReady(readyA),
    .Busy(busyA), .KeyState(ksA), .CmdDone(doneA),
    .CmdKey(cmdKeyA), .Overrun(ovrA)
  );

  key_cmd_streamer #(
    .NUM_KEYS(2), .DEBOUNCE_CYCLES(DB), .MAX_BYTES(6),
    .CMD_TABLE(TABLE), .CMD_LEN(LENS), .KEY_ACTIVE_LOW(1'b1),
    .REPEAT_EN(1'b1), .REPEAT_CYCLES(RC)
  ) dutB (
    .Clk(Clk), .Rst(Rst), .Key(keyB), .TxData(dataB),
    .TxValid(validB), .TxLast(lastB), .TxReady(readyB),
    .Busy(busyB), .KeyState(ksB), .CmdDone(doneB),
    .CmdKey(cmdKeyB), .Overrun(ovrB)
  );

  logic [8:0] expQ[$];
  logic [8:0] gotA[$];
  logic [8:0] gotB[$];
  int hsCyc[$];
  int cyc = 0;
  int hsA = 0, doneCntA = 0, ovrCntA = 0, stallErrA = 0;
  int hsB = 0, doneCntB = 0, ovrCntB = 0;
  int ksRiseCyc = 0, vRiseCyc = 0;
  logic pStall = 1'b0, pLast = 1'b0, pValid = 1'b0, pKs = 1'b0;
  logic [7:0] pData = 8'h00;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (!Rst) begin
      if (validA && readyA) begin
        gotA.push_back({lastA, dataA});
        hsCyc.push_back(cyc);
        hsA++;
      end
      if (pStall && !(validA && dataA == pData && lastA == pLast))
        stallErrA++;
      if (|ksA && !pKs) ksRiseCyc = cyc;
      if (validA && !pValid) vRiseCyc = cyc;
      if (validB && readyB) begin
        gotB.push_back({lastB, dataB});
        hsB++;
      end
    end
    if (doneA) doneCntA++;
    if (ovrA) ovrCntA++;
    if (doneB) doneCntB++;
    if (ovrB) ovrCntB++;
    pStall = !Rst && validA && !readyA;
    pData  = dataA;
    pLast  = lastA;
    pValid = validA;
    pKs    = |ksA;
  end

  function automatic void expectFrame(int k);
    for (int i = 0; i < refLen[k]; i++)
      expQ.push_back({i == refLen[k] - 1, refFrame[k][i]});
  endfunction

  function automatic int streamDiff(input logic [8:0] got[$], input int base);
    int n = 0;
    int have = got.size() - base;
    n = (have > expQ.size()) ? have - expQ.size() : expQ.size() - have;
    for (int i = 0; i < expQ.size() && i < have; i++)
      if (got[base + i] !== expQ[i]) n++;
    return n;
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick(3);
    @(negedge Clk);
    nChk++;
    if ({dataA, validA, lastA, busyA, ksA, doneA, cmdKeyA, ovrA} !== '0) begin
      nFail++;
      $display("FAIL reset_a: got %h %b %b %b %b %b %b %b want all 0",
               dataA, validA, lastA, busyA, ksA, doneA, cmdKeyA, ovrA);
    end
    nChk++;
    if ({dataB, validB, lastB, busyB, ksB, doneB, cmdKeyB, ovrB} !== '0) begin
      nFail++;
      $display("FAIL reset_b: got %h %b %b %b %b %b %b %b want all 0",
               dataB, validB, lastB, busyB, ksB, doneB, cmdKeyB, ovrB);
    end
    tick(1);
    Rst = 1'b0;
    tick(20);
    nChk++;
    if (hsA + doneCntA + int'(busyA) !== 0) begin
      nFail++;
      $display("FAIL idle_after_reset: hs=%0d done=%0d busy=%b want 0",
               hsA, doneCntA, busyA);
    end
  endtask

  task automatic test_basic_press();
    int g0 = gotA.size();
    int d0 = doneCntA;
    expQ.delete();
    expectFrame(0);
    readyA = 1'b1;
    keyA[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (i == 8) begin
        nChk++;
        if (ksA !== 2'b01) begin
          nFail++;
          $display("FAIL basic_keystate: got %b want 01", ksA);
        end
      end
    end
    keyA[0] = 1'b1;
    for (int i = 0; i < 100 && doneCntA == d0; i++) tick(1);
    tick(20);
    nChk++;
    if (streamDiff(gotA, g0) !== 0) begin
      nFail++;
      $display("FAIL basic_stream: %0d bytes got, %0d wanted, diff %0d",
               gotA.size() - g0, expQ.size(), streamDiff(gotA, g0));
    end
    nChk++;
    if (doneCntA - d0 !== 1) begin
      nFail++;
      $display("FAIL basic_done: got %0d pulses want 1", doneCntA - d0);
    end
    nChk++;
    if (cmdKeyA !== 1'b0) begin
      nFail++;
      $display("FAIL basic_cmdkey: got %b want 0", cmdKeyA);
    end
    nChk++;
    if (vRiseCyc - ksRiseCyc !== 2) begin
      nFail++;
      $display("FAIL basic_latency: got %0d want 2", vRiseCyc - ksRiseCyc);
    end
    nChk++;
    if (hsCyc.size() < g0 + 5 || hsCyc[hsCyc.size() - 1] - hsCyc[g0] !== 4) begin
      nFail++;
      $display("FAIL basic_consecutive: span not 4 cycles for 5 bytes");
    end
  endtask

  task automatic test_bounce();
    int h0 = hsA;
    logic seenKs = 1'b0;
    logic seenValid = 1'b0;
    int t = 0;
    while (t < 20) begin
      int r = $urandom_range(1, 3);
      keyA[1] = ~keyA[1];
      for (int i = 0; i < r; i++) begin
        tick(1);
        seenKs |= ksA[1];
        seenValid |= validA;
      end
      t += r;
    end
    keyA[1] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      seenKs |= ksA[1];
      seenValid |= validA;
    end
    nChk++;
    if (seenKs !== 1'b0) begin
      nFail++;
      $display("FAIL bounce_keystate: got %b want 0", seenKs);
    end
    nChk++;
    if ({seenValid, hsA != h0} !== 2'b00) begin
      nFail++;
      $display("FAIL bounce_tx: valid=%b hs=%0d want none", seenValid, hsA - h0);
    end
  endtask

  task automatic test_backpressure();
    int g0 = gotA.size();
    int h0 = hsA;
    int d0 = doneCntA;
    int s0 = stallErrA;
    expQ.delete();
    expectFrame(1);
    for (int i = 0; i < 200 && doneCntA == d0; i++) begin
      keyA[1] = (i < 10) ? 1'b0 : 1'b1;
      readyA = (i % 3 == 0);
      tick(1);
    end
    keyA[1] = 1'b1;
    readyA = 1'b1;
    tick(20);
    nChk++;
    if (streamDiff(gotA, g0) !== 0) begin
      nFail++;
      $display("FAIL bp_stream: %0d bytes got, %0d wanted", gotA.size() - g0, expQ.size());
    end
    nChk++;
    if (hsA - h0 !== 6) begin
      nFail++;
      $display("FAIL bp_handshakes: got %0d want 6", hsA - h0);
    end
    nChk++;
    if (stallErrA - s0 !== 0) begin
      nFail++;
      $display("FAIL bp_stable: got %0d unstable stalls want 0", stallErrA - s0);
    end
    nChk++;
    if ({doneCntA - d0, int'(cmdKeyA)} !== {32'd1, 32'd1}) begin
      nFail++;
      $display("FAIL bp_done_key: done=%0d key=%b want 1,1", doneCntA - d0, cmdKeyA);
    end
  endtask

  task automatic test_simultaneous();
    int g0 = gotA.size();
    int d0 = doneCntA;
    int o0 = ovrCntA;
    expQ.delete();
    expectFrame(0);
    expectFrame(1);
    readyA = 1'b1;
    keyA = 2'b00;
    tick(10);
    keyA = 2'b11;
    for (int i = 0; i < 100 && doneCntA - d0 < 2; i++) tick(1);
    tick(20);
    nChk++;
    if (streamDiff(gotA, g0) !== 0) begin
      nFail++;
      $display("FAIL simul_stream: %0d bytes got, %0d wanted", gotA.size() - g0, expQ.size());
    end
    nChk++;
    if (doneCntA - d0 !== 2) begin
      nFail++;
      $display("FAIL simul_done: got %0d want 2", doneCntA - d0);
    end
    nChk++;
    if (ovrCntA - o0 !== 0) begin
      nFail++;
      $display("FAIL simul_overrun: got %0d want 0", ovrCntA - o0);
    end
    nChk++;
    if (hsCyc.size() < g0 + 6 || hsCyc[g0 + 5] - hsCyc[g0 + 4] !== 3) begin
      nFail++;
      $display("FAIL simul_gap: frame gap is not 2 idle cycles");
    end
  endtask

  task automatic test_reset_midframe();
    int h0 = hsA;
    int d0 = doneCntA;
    int g0;
    logic seenBusy = 1'b0;
    readyA = 1'b1;
    keyA[1] = 1'b0;
    for (int i = 0; i < 60 && hsA < h0 + 2; i++) begin
      if (i == 8) keyA[1] = 1'b1;
      tick(1);
    end
    keyA[1] = 1'b1;
    nChk++;
    if (hsA - h0 !== 2) begin
      nFail++;
      $display("FAIL mid_reach: got %0d handshakes want 2", hsA - h0);
    end
    Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    @(negedge Clk);
    nChk++;
    if ({dataA, validA, lastA, busyA, ksA, doneA, cmdKeyA, ovrA} !== '0) begin
      nFail++;
      $display("FAIL mid_reset_outputs: got %h %b %b %b %b %b %b %b want all 0",
               dataA, validA, lastA, busyA, ksA, doneA, cmdKeyA, ovrA);
    end
    for (int i = 0; i < 30; i++) begin
      tick(1);
      seenBusy |= busyA;
    end
    nChk++;
    if ({seenBusy, doneCntA != d0, hsA != h0 + 2} !== 3'b000) begin
      nFail++;
      $display("FAIL mid_idle: busy=%b done=%0d hs=%0d want idle",
               seenBusy, doneCntA - d0, hsA - h0);
    end
    g0 = gotA.size();
    expQ.delete();
    expectFrame(1);
    keyA[1] = 1'b0;
    tick(10);
    keyA[1] = 1'b1;
    for (int i = 0; i < 100 && doneCntA == d0; i++) tick(1);
    tick(10);
    nChk++;
    if (streamDiff(gotA, g0) !== 0 || doneCntA - d0 !== 1) begin
      nFail++;
      $display("FAIL mid_repress: bytes=%0d done=%0d want 6,1",
               gotA.size() - g0, doneCntA - d0);
    end
  endtask

  task automatic test_repeat();
    int g0 = gotB.size();
    int d0 = doneCntB;
    int o0 = ovrCntB;
    int hold = $urandom_range(36, 44);
    expQ.delete();
    expectFrame(0);
    expectFrame(0);
    readyB = 1'b0;
    keyB[0] = 1'b0;
    tick(hold);
    keyB[0] = 1'b1;
    tick(14);
    readyB = 1'b1;
    for (int i = 0; i < 100 && doneCntB - d0 < 2; i++) tick(1);
    tick(40);
    nChk++;
    if ((ovrCntB - o0 >= 1) !== 1'b1) begin
      nFail++;
      $display("FAIL rep_overrun: got %0d pulses want >=1", ovrCntB - o0);
    end
    nChk++;
    if (doneCntB - d0 !== 2) begin
      nFail++;
      $display("FAIL rep_frames: got %0d frames want 2", doneCntB - d0);
    end
    nChk++;
    if (streamDiff(gotB, g0) !== 0) begin
      nFail++;
      $display("FAIL rep_stream: %0d bytes got, %0d wanted", gotB.size() - g0, expQ.size());
    end
  endtask

  task automatic test_random();
    int g0 = gotA.size();
    int d0 = doneCntA;
    int s0 = stallErrA;
    int want = 0;
    expQ.delete();
    for (int n = 0; n < 6; n++) begin
      logic [1:0] mask = 2'($urandom_range(1, 3));
      int hold = $urandom_range(6, 14);
      int dn = doneCntA;
      int cnt = int'(mask[0]) + int'(mask[1]);
      if (mask[0]) expectFrame(0);
      if (mask[1]) expectFrame(1);
      want += cnt;
      for (int i = 0; i < 300 && doneCntA - dn < cnt; i++) begin
        keyA = (i < hold) ? ~mask : 2'b11;
        readyA = 1'($urandom_range(0, 1));
        tick(1);
      end
      keyA = 2'b11;
      readyA = 1'b1;
      tick(20);
    end
    nChk++;
    if (streamDiff(gotA, g0) !== 0) begin
      nFail++;
      $display("FAIL rand_stream: %0d bytes got, %0d wanted, diff %0d",
               gotA.size() - g0, expQ.size(), streamDiff(gotA, g0));
    end
    nChk++;
    if (doneCntA - d0 !== want) begin
      nFail++;
      $display("FAIL rand_done: got %0d want %0d", doneCntA - d0, want);
    end
    nChk++;
    if (stallErrA - s0 !== 0) begin
      nFail++;
      $display("FAIL rand_stable: got %0d unstable stalls want 0", stallErrA - s0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_press();
    test_bounce();
    test_backpressure();
    test_simultaneous();
    test_reset_midframe();
    test_repeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule

// File: doc/key_cmd_streamer.md
Name: key_cmd_streamer

Overview:
Parametrised key-to-command generator. Debounces NUM_KEYS push-buttons and maps each press to a per-key command frame of up to MAX_BYTES bytes. Streams the frame byte-by-byte over a valid/ready interface to the UART transmitter feeding the radar/sensor module. Adds over the single-shot frame controller: queued presses, optional auto-repeat while held, and backpressure.

Parameters:
NUM_KEYS, 2, number of key inputs (1..8)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a new key level (20 ms at 50 MHz)
MAX_BYTES, 6, maximum frame length in bytes
CMD_TABLE, {key1: 55 5A 03 D1 01 84, key0: 55 5A 02 D3 84 00}, NUM_KEYS*MAX_BYTES*8 bits; byte i of key k at bits [(k*MAX_BYTES+i)*8 +: 8]
CMD_LEN, {6,5}, NUM_KEYS*4 bits; frame length of key k at [k*4 +: 4]
KEY_ACTIVE_LOW, 1, 1 = pressed when input is 0
REPEAT_EN, 0, 1 = re-issue the command every REPEAT_CYCLES while the key stays pressed
REPEAT_CYCLES, 50000000, auto-repeat period (1 s)

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous reset, active-high
Key  in  NUM_KEYS  raw asynchronous key inputs
TxData  out  8  current command byte
TxValid  out  1  TxData valid
TxLast  out  1  marks the final byte of a frame, qualified by TxValid
TxReady  in  1  downstream accepts the byte when TxValid && TxReady
Busy  out  1  frame in progress (state != IDLE)
KeyState  out  NUM_KEYS  debounced pressed state, 1 = pressed
CmdDone  out  1  one-cycle pulse after the last byte handshakes
CmdKey  out  max(1,$clog2(NUM_KEYS))  index of the key whose frame is or was last sent
Overrun  out  1  one-cycle pulse when a press event hits a key whose pending flag is already set

Behaviour:
- Reset (Rst=1 on a Clk edge): TxData=0, TxValid=0, TxLast=0, Busy=0, KeyState=0, CmdDone=0, CmdKey=0, Overrun=0. All pending flags, debounce counters and repeat counters clear. FSM goes to IDLE. Reset mid-frame abandons the frame with no CmdDone. A key held through reset re-debounces and then produces a press event.
- Input path per key: 2-FF synchroniser, then polarity normalisation per KEY_ACTIVE_LOW.
- Debounce: while the synchronised level differs from KeyState[k], a counter increments; otherwise it clears. When the count reaches DEBOUNCE_CYCLES-1, KeyState[k] takes the new level and the counter clears.
- Press event: a KeyState[k] 0->1 transition. With REPEAT_EN=1, an additional event fires every REPEAT_CYCLES cycles while KeyState[k]=1; the repeat counter clears on release. Release generates no event.
- Pending: an event sets pending[k] in the cycle after the event. An event while pending[k]=1 pulses Overrun; the flag stays set, so no double queueing.
- FSM states:
  - IDLE: if any pending is set, select the lowest index k, clear pending[k], latch k into CmdKey and len=min(CMD_LEN[k],MAX_BYTES), go to SEND. If len=0, clear the flag, send nothing, and pulse no CmdDone.
  - SEND: TxValid=1, TxData=byte idx of key k, TxLast=(idx==len-1). On handshake with idx<len-1, increment idx. On handshake of the last byte, go to DONE.
  - DONE: CmdDone=1 for one cycle, TxValid=0, then IDLE.
- Latency: KeyState rises at cycle t, pending is set at t+1, and TxValid with byte 0 appears at t+2 when IDLE. Back-to-back frames have a minimum 2-cycle gap (DONE, IDLE).
- Handshake: TxData and TxLast stay stable while TxValid && !TxReady. TxValid never drops without a handshake, except on reset. TxReady held high gives 1 byte per cycle.
- Simultaneous events on several keys set all their pending flags. They are served in ascending index order, one frame each.
- A new event for key k during its own frame sets pending[k] again, so the frame is resent afterwards.

Decomposition:
- Package key_cmd_pkg holds:
  - FSM state enum (IDLE, SEND, DONE)
  - default frame constants (query 55 5A 02 D3 84; radar on 55 5A 03 D1 01 84; radar off 55 5A 03 D1 00 83)
  - index width helper function
- Sub-module key_debounce (synchroniser, debounce counter, press/repeat event), one instance per key via generate.

Test Plan:
- Basic press: DEBOUNCE_CYCLES=4, TxReady=1, Key[0] low for 10 cycles -> KeyState[0]=1; bytes 55,5A,02,D3,84 on consecutive cycles; TxLast on 84; CmdDone once; CmdKey=0.
- Bounce rejection: Key[1] toggles every 2 cycles for 20 cycles, then stays high -> no KeyState change and no TxValid.
- Backpressure: key1 press with TxReady toggling 1,0,0,1,... -> frame 55 5A 03 D1 01 84 delivered intact; data stable during stalls; exactly 6 handshakes.
- Simultaneous press: key0 and key1 debounce on the same cycle -> key0 frame (5 bytes), then key1 frame (6 bytes); two CmdDone pulses; no Overrun.
- Overrun/repeat: REPEAT_EN=1, REPEAT_CYCLES=8, TxReady=0, key0 held 40 cycles -> at least one Overrun pulse; after TxReady=1, exactly 2 key0 frames are sent.
- Reset mid-frame: Rst=1 after the 2nd byte handshake -> next cycle all outputs are 0; no CmdDone; idle until a new debounced press.
